// File: rtl/eth_clk_rst_seq.sv
// Ethernet PLL power-up/relock sequencer: pulses the PLL reset, waits for stable lock,
// then releases the Ethernet domain reset; re-initialises the PLL on lock loss or timeout.
module eth_clk_rst_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W               = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_i,
    output logic       pll_rst_o,
    output logic       eth_rst_o,
    output logic       ready_o,
    output logic       timeout_o,
    output logic [7:0] retry_cnt_o
);

    typedef enum logic [3:0] {
        ST_PLL_RST   = 4'b0001,
        ST_WAIT_LOCK = 4'b0010,
        ST_STABLE    = 4'b0100,
        ST_RUN       = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_t             state, state_nxt;
    logic               lock_meta, lock_s;
    logic [CNT_W-1:0]   rst_cnt, rst_cnt_nxt;
    logic [CNT_W-1:0]   to_cnt, to_cnt_nxt;
    logic [CNT_W-1:0]   stab_cnt, stab_cnt_nxt;
    logic               timeout_nxt;
    logic               retry_inc;
    logic [7:0]         retry_nxt;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt    = state;
        rst_cnt_nxt  = rst_cnt;
        to_cnt_nxt   = to_cnt;
        stab_cnt_nxt = stab_cnt;
        timeout_nxt  = 1'b0;
        retry_inc    = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt   = ST_WAIT_LOCK;
                    rst_cnt_nxt = '0;
                    to_cnt_nxt  = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + CNT_W'(1);
                end
            end
            // Timeout compares with >= so an attempt that overshoots the last count still retries.
            ST_WAIT_LOCK: begin
                to_cnt_nxt = to_cnt + CNT_W'(1);
                if (lock_s) begin
                    state_nxt    = ST_STABLE;
                    stab_cnt_nxt = '0;
                end else if (to_cnt >= TO_LAST) begin
                    state_nxt   = ST_PLL_RST;
                    rst_cnt_nxt = '0;
                    timeout_nxt = 1'b1;
                    retry_inc   = 1'b1;
                end
            end
            ST_STABLE: begin
                to_cnt_nxt   = to_cnt + CNT_W'(1);
                stab_cnt_nxt = stab_cnt + CNT_W'(1);
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (stab_cnt == STAB_LAST) begin
                    state_nxt = ST_RUN;
                end else if (to_cnt >= TO_LAST) begin
                    state_nxt   = ST_PLL_RST;
                    rst_cnt_nxt = '0;
                    timeout_nxt = 1'b1;
                    retry_inc   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt   = ST_PLL_RST;
                    rst_cnt_nxt = '0;
                    retry_inc   = 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_PLL_RST;
                rst_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        retry_nxt = retry_cnt_o;
        if (retry_inc && (retry_cnt_o != 8'hFF)) begin
            retry_nxt = retry_cnt_o + 8'd1;
        end
    end

    // Outputs are registered from the next state so each one leaves a flop directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_PLL_RST;
            rst_cnt     <= '0;
            to_cnt      <= '0;
            stab_cnt    <= '0;
            pll_rst_o   <= 1'b1;
            eth_rst_o   <= 1'b1;
            ready_o     <= 1'b0;
            timeout_o   <= 1'b0;
            retry_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            stab_cnt    <= stab_cnt_nxt;
            pll_rst_o   <= (state_nxt == ST_PLL_RST);
            eth_rst_o   <= (state_nxt != ST_RUN);
            ready_o     <= (state_nxt == ST_RUN);
            timeout_o   <= timeout_nxt;
            retry_cnt_o <= retry_nxt;
        end
    end

endmodule

// File: tb/tb_eth_clk_rst_seq.sv
// Bench for eth_clk_rst_seq: per-cycle comparison against a phase/age model of the
// sequencer, plus directed scenarios with hand-computed cycle positions.
module tb_eth_clk_rst_seq;

    localparam int P_RST  = 4;
    localparam int P_STAB = 8;
    localparam int P_TO   = 32;

    localparam int PH_PLLRST = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       pll_rst_o;
    logic       eth_rst_o;
    logic       ready_o;
    logic       timeout_o;
    logic [7:0] retry_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    int m_phase   = PH_PLLRST;
    int m_age     = 0;
    int m_attempt = 0;
    int m_stable  = 0;
    int m_retry   = 0;
    bit m_timeout = 1'b0;
    bit m_s1      = 1'b0;
    bit m_s2      = 1'b0;

    eth_clk_rst_seq #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STAB),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .CNT_W               (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock_i  (pll_lock_i),
        .pll_rst_o   (pll_rst_o),
        .eth_rst_o   (eth_rst_o),
        .ready_o     (ready_o),
        .timeout_o   (timeout_o),
        .retry_cnt_o (retry_cnt_o)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l);
        rst        = r;
        pll_lock_i = l;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves rst low at a falling edge; that edge is cycle 0 of each scenario.
    task automatic doReset(input logic l);
        applyStimulus(1'b1, l);
        tick(3);
        applyStimulus(1'b0, l);
    endtask

    // Model: phase plus ages counted in whole cycles since entering the phase / attempt.
    always @(posedge clk) begin : model
        int ph, age, att, stb, rty;
        bit tmo, ls;
        ls  = m_s2;
        ph  = m_phase;
        age = m_age;
        att = m_attempt;
        stb = m_stable;
        rty = m_retry;
        tmo = 1'b0;
        if (rst) begin
            ph = PH_PLLRST; age = 0; att = 0; stb = 0; rty = 0;
            m_s1 <= 1'b0;
            m_s2 <= 1'b0;
        end else begin
            m_s1 <= pll_lock_i;
            m_s2 <= m_s1;
            case (ph)
                PH_PLLRST: begin
                    age++;
                    if (age == P_RST) begin ph = PH_WAIT; att = 0; end
                end
                PH_WAIT: begin
                    att++;
                    if (ls) begin ph = PH_STABLE; stb = 0; end
                    else if (att == P_TO) begin
                        ph = PH_PLLRST; age = 0; tmo = 1'b1;
                        if (rty < 255) rty++;
                    end
                end
                PH_STABLE: begin
                    att++;
                    stb++;
                    if (!ls) ph = PH_WAIT;
                    else if (stb == P_STAB) ph = PH_RUN;
                    else if (att == P_TO) begin
                        ph = PH_PLLRST; age = 0; tmo = 1'b1;
                        if (rty < 255) rty++;
                    end
                end
                default: begin
                    if (!ls) begin
                        ph = PH_PLLRST; age = 0;
                        if (rty < 255) rty++;
                    end
                end
            endcase
        end
        m_phase   <= ph;
        m_age     <= age;
        m_attempt <= att;
        m_stable  <= stb;
        m_retry   <= rty;
        m_timeout <= tmo;
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_pll_rst", {31'd0, pll_rst_o}, {31'd0, m_phase == PH_PLLRST});
            checkOutput("model_eth_rst", {31'd0, eth_rst_o}, {31'd0, m_phase != PH_RUN});
            checkOutput("model_ready", {31'd0, ready_o}, {31'd0, m_phase == PH_RUN});
            checkOutput("model_timeout", {31'd0, timeout_o}, {31'd0, m_timeout});
            checkOutput("model_retry", {24'd0, retry_cnt_o}, m_retry);
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt, ti, np, w, prst;
        int pulses[$];
        int rts[$];

        applyStimulus(1'b1, 1'b0);
        tick(2);
        check_en = 1'b1;
        checkOutput("rst_pll_rst", {31'd0, pll_rst_o}, 1);
        checkOutput("rst_eth_rst", {31'd0, eth_rst_o}, 1);
        checkOutput("rst_ready", {31'd0, ready_o}, 0);
        checkOutput("rst_timeout", {31'd0, timeout_o}, 0);
        checkOutput("rst_retry", {24'd0, retry_cnt_o}, 0);

        $display("[TB] clean power-up and relock");
        doReset(1'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst_o === 1'b1) cnt++;
            tick(1);
        end
        checkOutput("pwr_pll_rst_len", cnt, 4);
        applyStimulus(1'b0, 1'b1);
        tick(10);
        checkOutput("pwr_ready_c20", {31'd0, ready_o}, 0);
        tick(1);
        checkOutput("pwr_ready_c21", {31'd0, ready_o}, 1);
        checkOutput("pwr_eth_rst_c21", {31'd0, eth_rst_o}, 0);
        checkOutput("pwr_retry", {24'd0, retry_cnt_o}, 0);
        tick(9);
        applyStimulus(1'b0, 1'b0);
        tick(2);
        checkOutput("relock_ready_c32", {31'd0, ready_o}, 1);
        tick(1);
        checkOutput("relock_ready_c33", {31'd0, ready_o}, 0);
        checkOutput("relock_eth_rst_c33", {31'd0, eth_rst_o}, 1);
        checkOutput("relock_pll_rst_c33", {31'd0, pll_rst_o}, 1);
        checkOutput("relock_timeout_c33", {31'd0, timeout_o}, 0);
        checkOutput("relock_retry", {24'd0, retry_cnt_o}, 1);
        tick(2);
        applyStimulus(1'b0, 1'b1);
        tick(10);
        checkOutput("relock_ready_c45", {31'd0, ready_o}, 0);
        tick(1);
        checkOutput("relock_ready_c46", {31'd0, ready_o}, 1);
        checkOutput("relock_retry_run", {24'd0, retry_cnt_o}, 1);

        $display("[TB] lock timeout");
        doReset(1'b0);
        prst = 0;
        for (int i = 0; i <= 110; i++) begin
            if (timeout_o === 1'b1) begin
                pulses.push_back(i);
                rts.push_back(int'(retry_cnt_o));
            end
            if (i >= 36 && i <= 43 && pll_rst_o === 1'b1) prst++;
            tick(1);
        end
        checkOutput("to_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            checkOutput("to_pulse0_cycle", pulses[0], 36);
            checkOutput("to_pulse1_cycle", pulses[1], 72);
            checkOutput("to_pulse2_cycle", pulses[2], 108);
            checkOutput("to_retry0", rts[0], 1);
            checkOutput("to_retry1", rts[1], 2);
            checkOutput("to_retry2", rts[2], 3);
        end
        checkOutput("to_pll_rst_len", prst, 4);

        $display("[TB] reset coinciding with a timeout");
        doReset(1'b0);
        tick(35);
        applyStimulus(1'b1, 1'b0);
        tick(1);
        checkOutput("rstwin_timeout", {31'd0, timeout_o}, 0);
        checkOutput("rstwin_retry", {24'd0, retry_cnt_o}, 0);

        $display("[TB] flaky lock within budget");
        doReset(1'b1);
        tick(10);
        applyStimulus(1'b0, 1'b0);
        tick(3);
        checkOutput("flaky_ready_c13", {31'd0, ready_o}, 0);
        applyStimulus(1'b0, 1'b1);
        tick(10);
        checkOutput("flaky_ready_c23", {31'd0, ready_o}, 0);
        tick(1);
        checkOutput("flaky_ready_c24", {31'd0, ready_o}, 1);
        checkOutput("flaky_retry", {24'd0, retry_cnt_o}, 0);

        $display("[TB] flaky lock beyond budget");
        doReset(1'b1);
        tick(10);
        applyStimulus(1'b0, 1'b0);
        ti = -1;
        for (int i = 10; i < 45; i++) begin
            if (timeout_o === 1'b1 && ti < 0) ti = i;
            tick(1);
        end
        checkOutput("flaky_timeout_cycle", ti, 36);
        checkOutput("flaky_timeout_retry", {24'd0, retry_cnt_o}, 1);

        $display("[TB] retry saturation and reset from RUN");
        doReset(1'b0);
        np = 0;
        for (int i = 0; i < 260 * 36 + 10; i++) begin
            if (timeout_o === 1'b1) np++;
            tick(1);
        end
        checkOutput("sat_pulses", np, 260);
        checkOutput("sat_retry", {24'd0, retry_cnt_o}, 255);
        applyStimulus(1'b0, 1'b1);
        w = 0;
        while (ready_o !== 1'b1 && w < 100) begin
            tick(1);
            w++;
        end
        checkOutput("sat_reach_run", {31'd0, w < 100}, 1);
        checkOutput("sat_retry_run", {24'd0, retry_cnt_o}, 255);
        applyStimulus(1'b1, 1'b1);
        tick(1);
        checkOutput("runrst_pll_rst", {31'd0, pll_rst_o}, 1);
        checkOutput("runrst_eth_rst", {31'd0, eth_rst_o}, 1);
        checkOutput("runrst_ready", {31'd0, ready_o}, 0);
        checkOutput("runrst_timeout", {31'd0, timeout_o}, 0);
        checkOutput("runrst_retry", {24'd0, retry_cnt_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
